// File: rtl/product_bcd_display.sv
// Captures an 8-bit product, converts it to BCD with a bit-serial double-dabble
// engine, and scans the three digits onto a multiplexed 7-segment display.
`timescale 1ns/1ps
module product_bcd_display #(
  parameter int unsigned REFRESH_DIV   = 1024,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] prod_in,
  input  logic       prod_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [6:0] seg,
  output logic [2:0] dig_sel
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] scratch_q, scratch_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  hund_q, tens_q, ones_q;
  logic        armed_q;
  logic        accept;
  logic        last_shift;

  logic [15:0] scan_q;
  logic [1:0]  idx_q;
  logic [6:0]  seg_q, seg_d;
  logic [2:0]  dig_sel_q, dig_sel_d;
  logic [3:0]  cur_digit;
  logic        blank;
  logic        scan_wrap;

  function automatic logic [11:0] add3_adjust(input logic [11:0] s);
    logic [11:0] r;
    for (int n = 0; n < 3; n++) begin
      r[n*4 +: 4] = (s[n*4 +: 4] >= 4'd5) ? s[n*4 +: 4] + 4'd3 : s[n*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // armed_q keeps a strobe coincident with reset release from being taken.
  assign accept     = (state_q == IDLE) && prod_valid && armed_q;
  assign last_shift = (state_q == SHIFT) && (bit_cnt_q == 4'd8);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; comb blocks use blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      shreg_d   = prod_in;
      scratch_d = '0;
      bit_cnt_d = '0;
    end else if (state_q == SHIFT && !last_shift) begin
      {scratch_d, shreg_d} = {add3_adjust(scratch_q), shreg_q} << 1;
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
  end

  // NOTE: the datapath is small and feeds visible outputs, so it is reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      bit_cnt_q <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      bit_cnt_q <= bit_cnt_d;
      armed_q   <= 1'b1;
      if (last_shift) begin
        hund_q <= scratch_q[11:8];
        tens_q <= scratch_q[7:4];
        ones_q <= scratch_q[3:0];
      end
    end
  end

  assign bcd_hund = hund_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;

  // Display scan: index 0 = ones, 1 = tens, 2 = hundreds.
  assign scan_wrap = (scan_q == 16'(REFRESH_DIV - 1));

  always_comb begin
    cur_digit = ones_q;
    blank     = 1'b0;
    dig_sel_d = 3'b001;
    case (idx_q)
      2'd1: begin
        cur_digit = tens_q;
        blank     = BLANK_LEADING && (hund_q == 4'd0) && (tens_q == 4'd0);
        dig_sel_d = 3'b010;
      end
      2'd2: begin
        cur_digit = hund_q;
        blank     = BLANK_LEADING && (hund_q == 4'd0);
        dig_sel_d = 3'b100;
      end
      default: ;
    endcase
    seg_d = blank ? 7'b0000000 : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q    <= '0;
      idx_q     <= '0;
      seg_q     <= 7'b0111111;
      dig_sel_q <= 3'b001;
    end else begin
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
      if (scan_wrap) begin
        scan_q <= '0;
        idx_q  <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 16'd1;
      end
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: doc/product_bcd_display.md
Name: product_bcd_display

Overview:
- Downstream consumer of the shift-add multiplier datapath's 8-bit product (uo_out path).
- Captures the product and converts it to three BCD digits with a sequential double-dabble engine.
- Drives a time-multiplexed 3-digit 7-segment display, with optional leading-zero blanking.
- Sits between the datapath product register and the top-level pins.

Parameters:
- REFRESH_DIV, 1024: clock cycles each digit is displayed before the scan advances; legal range 2..65535.
- BLANK_LEADING, 1: when 1, leading zero digits are blanked; when 0, all three digits are always shown.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- prod_in  input  8  unsigned product from the datapath (0..255).
- prod_valid  input  1  single-cycle strobe; prod_in is valid in this cycle.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking that the BCD outputs have just been updated.
- bcd_hund  output  4  hundreds digit (0..2).
- bcd_tens  output  4  tens digit (0..9).
- bcd_ones  output  4  ones digit (0..9).
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- dig_sel  output  3  one-hot digit enable, active-high: bit0 = ones, bit1 = tens, bit2 = hundreds.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; the scan counter and digit index clear.
  - busy = 0, done = 0, bcd_hund = bcd_tens = bcd_ones = 0.
  - dig_sel = 3'b001, seg = 7'b0111111 (the digit "0").
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: prod_valid = 1 is sampled at a rising edge. That edge loads prod_in into an 8-bit shift register, clears the 12-bit BCD scratch and the bit counter, and moves the FSM to SHIFT. busy rises at this edge.
  - SHIFT: one bit per clock.
    - First, each scratch nibble >= 5 has 3 added (all three nibbles adjust in parallel).
    - Then {scratch, shreg} shifts left by 1.
    - After the 8th shift, the FSM moves to DONE.
  - DONE: lasts one cycle.
    - On entry, the scratch is copied into bcd_hund/tens/ones and done = 1.
    - At the next edge the FSM returns to IDLE; busy and done both fall.
- Latency: the capture edge is E0. Shifts occur at E1..E8. The outputs update and done rises at E9. busy is high from E0 to E10.
- prod_valid is accepted only in IDLE. It is ignored in SHIFT and DONE; there is no queueing and no error flag.
- bcd_* hold their value until the next conversion completes. A conversion in progress never alters the displayed value.
- Arithmetic: the scratch nibbles are 4-bit and saturate-free. The add-3 adjust never overflows because its input is <= 9.
- Scan:
  - A free-running counter counts 0..REFRESH_DIV-1.
  - When it wraps, the digit index advances ones -> tens -> hundreds -> ones.
  - dig_sel and seg are registered, so they change together one clock after the index changes.
- Segment decode, digits 0..9 (gfedcba): 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
- Any nibble > 9 decodes to 1000000 (dash). This cannot occur in normal operation.
- Blanking (BLANK_LEADING = 1):
  - The hundreds digit shows seg = 0 when bcd_hund == 0.
  - The tens digit shows seg = 0 when bcd_hund == 0 and bcd_tens == 0.
  - The ones digit is never blanked.
  - dig_sel still scans normally while a digit is blanked.
- Reset during SHIFT or DONE: the conversion is aborted, no done pulse is produced, and all reset values apply. After reset deasserts, the next prod_valid starts a fresh conversion.
- prod_valid in the same cycle that rst_n deasserts is ignored; the first accepted strobe is on the following edge.

Test Plan:
- Reset check: hold rst_n low, then release. Required: busy = 0, done = 0, bcd_* = 0, dig_sel = 001, seg = 0111111; scan advances after REFRESH_DIV cycles.
- Max value: prod_in = 225 (15×15) with a one-cycle strobe. Required: done exactly 9 edges later; bcd = 2/2/5; busy high for 10 cycles.
- Zero with blanking: prod_in = 0 with REFRESH_DIV = 4. Required: bcd = 0/0/0; over 12 cycles, seg sequence is 0111111 on ones and 0000000 on tens and hundreds.
- Strobe while busy: prod_in = 99, then prod_in = 42 strobed three cycles later. Required: a single done pulse and bcd = 0/9/9; the 42 is dropped.
- Mid-conversion reset: strobe prod_in = 137, then pulse rst_n low at E4. Required: no done pulse and bcd stays 0. A later strobe with 137 gives bcd = 1/3/7, shown as 0000110 / 1001111 / 0000111 across the scan.
- Exhaustive sweep: strobe prod_in = 0..255 back-to-back in IDLE. Required: every result matches the decimal digits, and done fires exactly once per accepted strobe.
